slave_port: RTL
===============

# slave_port

Slave-side responder for the bit-serial system bus. It sits behind the master mux and accepts the per-slave serial request bundle (valid, ready, read/write enable, serial address, data and burst). It executes single or burst writes and reads against a local synchronous memory. Read data returns bit-serially with a valid/ready handshake toward the slave-to-master return path.

## Interface
Parameters:
- ADDR_WIDTH, 12, serial address bits per transaction; also the local memory address width (depth 2^ADDR_WIDTH)
- DATA_WIDTH, 8, bits per data beat
- BURST_WIDTH, 4, serial burst-length field bits; beats = field+1 (1..16)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset; synchronous and active-high
- master_valid  in  1  master driving a valid serial bit on tx_address/tx_data
- master_ready  in  1  master accepts current rx_data bit
- read_en  in  1  request is a read (sampled at start)
- write_en  in  1  request is a write (sampled at start)
- tx_address  in  1  serial address, LSB first
- tx_burst  in  1  serial burst field, LSB first, parallel to first BURST_WIDTH address bits
- tx_data  in  1  serial write data, LSB first
- tx_done  in  1  master abort/terminate
- slave_ready  out  1  slave samples serial input bits this cycle
- slave_valid  out  1  rx_data carries a valid read bit
- rx_data  out  1  serial read data, LSB first
- slave_done  out  1  one-cycle pulse: transaction completed
- slave_err  out  1  one-cycle pulse: illegal request rejected

## Operation
- States: IDLE, ADDR, WDATA, RLOAD, RDATA.
- A bit is "accepted" on an edge where master_valid && slave_ready.
- slave_ready = 1 in IDLE, ADDR, WDATA; 0 in RLOAD, RDATA. slave_valid = 1 only in RDATA.
- IDLE: master_valid with exactly one of read_en/write_en → first address/burst bit accepted, latch op, go ADDR (bit count 1). Both enables high → no acceptance of address, slave_err pulses next cycle, stay IDLE. Neither high → ignore.
- ADDR: accept remaining address bits; tx_burst captured only for bit indices 0..BURST_WIDTH-1. On the ADDR_WIDTH-th bit: write → WDATA, read → RLOAD. If ADDR_WIDTH < BURST_WIDTH, missing burst bits are 0.
- WDATA: accept DATA_WIDTH bits per beat into a shift register. Memory is written at the edge after the last bit of a beat, using the current address. Address increments mod 2^ADDR_WIDTH per beat. No gap between beats. After the final beat: slave_done pulse, IDLE.
- RLOAD: 1 cycle; memory read issued at current address; next state RDATA with word loaded.
- RDATA: rx_data = shift register bit 0. The register shifts on each edge with master_ready high; it holds otherwise. After the last bit of a beat: if beats remain → address+1, RLOAD; else slave_done pulse, IDLE.
- tx_done high in any non-IDLE state → IDLE on next edge. Any partial write beat is discarded (no memory write). slave_done is not pulsed.
- master_valid low in ADDR/WDATA stalls the bit count; no timeout.
- rst mid-transaction → IDLE, counters cleared. Memory contents are not cleared by reset.
- Memory is unaffected by slave_err or ignored requests.

## Timing
- Reset values: slave_ready=1 (IDLE), slave_valid=0, rx_data=0, slave_done=0, slave_err=0; burst/bit/beat counters 0.
- Write, single beat, no stalls: request edge E0 (address bit 0).
  - Last address bit at E(ADDR_WIDTH-1).
  - Data bits at E(ADDR_WIDTH)..E(ADDR_WIDTH+DATA_WIDTH-1).
  - Memory write and slave_done high in the following cycle.
- Read, single beat, master_ready held high: address done at E(ADDR_WIDTH-1).
  - RLOAD for 1 cycle.
  - slave_valid high for DATA_WIDTH cycles.
  - slave_done pulses in the cycle after the last bit is accepted.
- Read burst: one-cycle slave_valid=0 bubble (RLOAD) between beats.
- slave_done and slave_err are exactly one cycle wide, registered.
- tx_done takes priority over a completing bit on the same edge.

## Test plan
- Reset, then single write addr 0x123 data 0xA5, then single read 0x123 → read bits LSB-first 1,0,1,0,0,1,0,1; slave_done pulses once per transaction; read latency from last address bit = 2 cycles to first valid bit.
- Burst write field=3 from 0xFFE with data 0x11,0x22,0x33,0x44 → memory 0xFFE=0x11, 0xFFF=0x22, 0x000=0x33, 0x001=0x44 (wrap); read burst returns same order with 3 single-cycle bubbles.
- Read with master_ready toggling 1,0,1,0 → each rx_data bit holds while ready is low; total DATA_WIDTH accepted bits, slave_done after the 8th acceptance.
- read_en=write_en=1 with master_valid → slave_err pulse one cycle, state IDLE, memory unchanged, no slave_done.
- Write to 0x050 aborted by tx_done after 5 data bits → memory 0x050 retains prior value 0x00; next request accepted immediately; rst asserted mid read burst → slave_valid=0 next cycle, IDLE.
- master_valid dropped for 3 cycles mid-address → bit count holds; transaction completes correctly with delay of exactly 3 cycles.

Source files
------------

// File: rtl/slave_port.sv
// Slave-side responder for the bit-serial system bus: serial address/burst/data
// capture, burst writes into local memory and bit-serial read return.
module slave_port #(
    parameter int ADDR_WIDTH  = 12,
    parameter int DATA_WIDTH  = 8,
    parameter int BURST_WIDTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic master_valid,
    input  logic master_ready,
    input  logic read_en,
    input  logic write_en,
    input  logic tx_address,
    input  logic tx_burst,
    input  logic tx_data,
    input  logic tx_done,
    output logic slave_ready,
    output logic slave_valid,
    output logic rx_data,
    output logic slave_done,
    output logic slave_err
);

    localparam int MAX_AD  = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int MAX_ALL = (MAX_AD > BURST_WIDTH) ? MAX_AD : BURST_WIDTH;
    localparam int CNT_W   = $clog2(MAX_ALL + 1);

    typedef enum logic [2:0] {IDLE, ADDR, WDATA, RLOAD, RDATA} state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       bitCnt_q, bitCnt_d;
    logic [BURST_WIDTH-1:0] burst_q, burst_d;
    logic [BURST_WIDTH-1:0] beatCnt_q, beatCnt_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic                   isRead_q, isRead_d;
    logic [DATA_WIDTH-1:0]  shift_q, shift_d;
    logic                   wrPend_q, wrPend_d;
    logic [ADDR_WIDTH-1:0]  wrAddr_q, wrAddr_d;
    logic [DATA_WIDTH-1:0]  wrWord_q, wrWord_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;

    logic [DATA_WIDTH-1:0]  mem [0:(2**ADDR_WIDTH)-1];

    // A completed write beat is committed one edge later, so the next beat can start without a gap.
    always_ff @(posedge clk) begin
        if (wrPend_q) begin
            mem[wrAddr_q] <= wrWord_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            bitCnt_q  <= '0;
            burst_q   <= '0;
            beatCnt_q <= '0;
            addr_q    <= '0;
            isRead_q  <= 1'b0;
            shift_q   <= '0;
            wrPend_q  <= 1'b0;
            wrAddr_q  <= '0;
            wrWord_q  <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bitCnt_q  <= bitCnt_d;
            burst_q   <= burst_d;
            beatCnt_q <= beatCnt_d;
            addr_q    <= addr_d;
            isRead_q  <= isRead_d;
            shift_q   <= shift_d;
            wrPend_q  <= wrPend_d;
            wrAddr_q  <= wrAddr_d;
            wrWord_q  <= wrWord_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bitCnt_d  = bitCnt_q;
        burst_d   = burst_q;
        beatCnt_d = beatCnt_q;
        addr_d    = addr_q;
        isRead_d  = isRead_q;
        shift_d   = shift_q;
        wrPend_d  = 1'b0;
        wrAddr_d  = wrAddr_q;
        wrWord_d  = wrWord_q;
        done_d    = 1'b0;
        err_d     = 1'b0;

        // An abort outranks whatever bit completes on the same edge.
        if (state_q != IDLE && tx_done) begin
            state_d   = IDLE;
            bitCnt_d  = '0;
            beatCnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (master_valid) begin
                        if (read_en && write_en) begin
                            err_d = 1'b1;
                        end else if (read_en || write_en) begin
                            isRead_d   = read_en;
                            addr_d     = {tx_address, addr_q[ADDR_WIDTH-1:1]};
                            burst_d    = '0;
                            burst_d[0] = tx_burst;
                            bitCnt_d   = CNT_W'(1);
                            beatCnt_d  = '0;
                            state_d    = ADDR;
                        end
                    end
                end
                ADDR: begin
                    if (master_valid) begin
                        addr_d = {tx_address, addr_q[ADDR_WIDTH-1:1]};
                        for (int i = 1; i < BURST_WIDTH; i++) begin
                            if (bitCnt_q == CNT_W'(i)) begin
                                burst_d[i] = tx_burst;
                            end
                        end
                        if (bitCnt_q == CNT_W'(ADDR_WIDTH - 1)) begin
                            bitCnt_d = '0;
                            state_d  = isRead_q ? RLOAD : WDATA;
                        end else begin
                            bitCnt_d = bitCnt_q + CNT_W'(1);
                        end
                    end
                end
                WDATA: begin
                    if (master_valid) begin
                        shift_d = {tx_data, shift_q[DATA_WIDTH-1:1]};
                        if (bitCnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                            bitCnt_d = '0;
                            wrPend_d = 1'b1;
                            wrAddr_d = addr_q;
                            wrWord_d = shift_d;
                            if (beatCnt_q == burst_q) begin
                                done_d  = 1'b1;
                                state_d = IDLE;
                            end else begin
                                beatCnt_d = beatCnt_q + BURST_WIDTH'(1);
                                addr_d    = addr_q + ADDR_WIDTH'(1);
                            end
                        end else begin
                            bitCnt_d = bitCnt_q + CNT_W'(1);
                        end
                    end
                end
                RLOAD: begin
                    shift_d  = mem[addr_q];
                    bitCnt_d = '0;
                    state_d  = RDATA;
                end
                RDATA: begin
                    if (master_ready) begin
                        shift_d = shift_q >> 1;
                        if (bitCnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                            bitCnt_d = '0;
                            if (beatCnt_q == burst_q) begin
                                done_d  = 1'b1;
                                state_d = IDLE;
                            end else begin
                                beatCnt_d = beatCnt_q + BURST_WIDTH'(1);
                                addr_d    = addr_q + ADDR_WIDTH'(1);
                                state_d   = RLOAD;
                            end
                        end else begin
                            bitCnt_d = bitCnt_q + CNT_W'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign slave_ready = (state_q == IDLE) || (state_q == ADDR) || (state_q == WDATA);
    assign slave_valid = (state_q == RDATA);
    assign rx_data     = slave_valid & shift_q[0];
    assign slave_done  = done_q;
    assign slave_err   = err_q;

endmodule
